iob_axi_mem_responder: RTL and testbench
========================================

Name: iob_axi_mem_responder

Overview:
- Synthesizable AXI4 slave (responder) backed by on-chip simple dual-port RAM.
- Terminates the SoC's external-memory AXI master port on boards/sims without DDR, or as a DDR stand-in for bring-up.
- Independent write (AW/W/B) and read (AR/R) FSMs run concurrently.
- Supports INCR and FIXED bursts at full bus width only.

Parameters:
AXI_ID_W, 1, ID width
AXI_LEN_W, 4, burst length field width (max 2^AXI_LEN_W beats)
AXI_ADDR_W, 24, byte address width
AXI_DATA_W, 32, data width (32/64/128); OFF = log2(AXI_DATA_W/8)
MEM_ADDR_W, 12, RAM word-address width (depth 2^MEM_ADDR_W words)

Ports:
clk_i  input  1  clock
arstn_i  input  1  async active-low reset
axi_awid_i / axi_arid_i  input  AXI_ID_W  write / read ID
axi_awaddr_i / axi_araddr_i  input  AXI_ADDR_W  start byte address
axi_awlen_i / axi_arlen_i  input  AXI_LEN_W  beats minus one
axi_awsize_i / axi_arsize_i  input  3  beat size
axi_awburst_i / axi_arburst_i  input  2  burst type
axi_awvalid_i / axi_arvalid_i  input  1  address valid
axi_awready_o / axi_arready_o  output  1  address ready
axi_wdata_i  input  AXI_DATA_W  write data
axi_wstrb_i  input  AXI_DATA_W/8  byte strobes
axi_wlast_i  input  1  last write beat
axi_wvalid_i / axi_wready_o  in/out  1  W handshake
axi_bid_o / axi_rid_o  output  AXI_ID_W  echoed awid / arid
axi_bresp_o / axi_rresp_o  output  2  0=OKAY, 2=SLVERR
axi_bvalid_o / axi_rvalid_o  output  1  response / read-data valid
axi_bready_i / axi_rready_i  input  1  master ready
axi_rdata_o  output  AXI_DATA_W  read data
axi_rlast_o  output  1  last read beat
axi_aw/arlock, cache, prot, qos _i  input  various  accepted, ignored

Behaviour:
- Reset: all outputs 0 asynchronously; awready/arready go 1 on first clk edge after arstn_i release. RAM contents not reset. Reset mid-burst aborts both FSMs to IDLE; already-written beats persist.
- Word address = addr[MEM_ADDR_W+OFF-1:OFF]; higher bits ignored (alias). Unaligned low bits ignored.
- Error: size != OFF, or burst = WRAP (2) / reserved (3) → whole burst flagged SLVERR. Writes suppressed; read beats return rdata 0. Beat counts unchanged.
- Address step: INCR +1 word per beat, modulo 2^MEM_ADDR_W (wraps last word → 0); FIXED holds address.
- Write FSM:
  - W_IDLE (awready=1): on awvalid latch id/addr/len/err → W_DATA.
  - W_DATA (wready=1): each wvalid beat writes RAM with per-byte wstrb.
  - Termination by beat count len+1, not wlast. wlast on beat ≠ len+1, or missing on final beat → SLVERR.
  - After final beat → W_RESP (bvalid=1, bid, bresp); hold until bready → W_IDLE, awready=1 next cycle.
- Read FSM:
  - R_IDLE (arready=1): on arvalid latch → R_FETCH (RAM read, 1-cycle latency) → R_DATA.
  - arvalid&arready to first rvalid = 2 cycles.
  - R_DATA: rdata/rresp/rlast registered and stable while rvalid & !rready. Next-word RAM read issued on each accepted beat → 1 beat/cycle sustained with rready high.
  - rlast=1 only on beat len+1. After its acceptance → R_IDLE.
- Write and read concurrent. Same-word read and write in same cycle → read returns old data.
- Max one outstanding transaction per direction. No interleaving, no reordering.

Test Plan:
- Write 0x10 ← 0xDEADBEEF, strb 0xF, awid 1; then read 0x10 → bresp 0, bid 1; rdata 0xDEADBEEF, rlast 1, rresp 0, rvalid 2 cycles after AR handshake.
- INCR len 3 write @0x100 data 1,2,3,4; read len 3 with rready=1 → 4 consecutive cycles rdata 1,2,3,4; rlast only on 4th.
- Write 0xFFFFFFFF @0x20, then 0x00AB0000 strb 0b0100 → read 0x20 = 0xFFABFFFF.
- Read len 7 with rready toggling every cycle → exactly 8 beats, in order; rdata/rlast stable during stalls.
- awsize=1 → bresp 2, RAM unchanged. WRAP read len 3 → 4 beats rresp 2, rdata 0. Early wlast on beat 2 of len 3 → 4 beats accepted, bresp 2. INCR len 1 at last word → 2nd beat accesses word 0.
- arstn_i low during read beat 2 → rvalid 0 immediately. Release → arready 1 next edge; fresh write/read of 0x5A5A5A5A completes correctly.

Source files
------------

// File: rtl/iob_axi_mem_responder_if.sv
// AXI4 bus bundle between the SoC external-memory master and the RAM responder.
// Member names match the original flat port names of the responder.
interface iob_axi_mem_responder_if #(
  parameter int AXI_ID_W   = 1,
  parameter int AXI_LEN_W  = 4,
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_DATA_W = 32
) ();
  // write address channel
  logic [AXI_ID_W-1:0]     axi_awid_i;
  logic [AXI_ADDR_W-1:0]   axi_awaddr_i;
  logic [AXI_LEN_W-1:0]    axi_awlen_i;
  logic [2:0]              axi_awsize_i;
  logic [1:0]              axi_awburst_i;
  logic                    axi_awlock_i;
  logic [3:0]              axi_awcache_i;
  logic [2:0]              axi_awprot_i;
  logic [3:0]              axi_awqos_i;
  logic                    axi_awvalid_i;
  logic                    axi_awready_o;
  // write data channel
  logic [AXI_DATA_W-1:0]   axi_wdata_i;
  logic [AXI_DATA_W/8-1:0] axi_wstrb_i;
  logic                    axi_wlast_i;
  logic                    axi_wvalid_i;
  logic                    axi_wready_o;
  // write response channel
  logic [AXI_ID_W-1:0]     axi_bid_o;
  logic [1:0]              axi_bresp_o;
  logic                    axi_bvalid_o;
  logic                    axi_bready_i;
  // read address channel
  logic [AXI_ID_W-1:0]     axi_arid_i;
  logic [AXI_ADDR_W-1:0]   axi_araddr_i;
  logic [AXI_LEN_W-1:0]    axi_arlen_i;
  logic [2:0]              axi_arsize_i;
  logic [1:0]              axi_arburst_i;
  logic                    axi_arlock_i;
  logic [3:0]              axi_arcache_i;
  logic [2:0]              axi_arprot_i;
  logic [3:0]              axi_arqos_i;
  logic                    axi_arvalid_i;
  logic                    axi_arready_o;
  // read data channel
  logic [AXI_ID_W-1:0]     axi_rid_o;
  logic [AXI_DATA_W-1:0]   axi_rdata_o;
  logic [1:0]              axi_rresp_o;
  logic                    axi_rlast_o;
  logic                    axi_rvalid_o;
  logic                    axi_rready_i;

  modport slave (
    input  axi_awid_i, axi_awaddr_i, axi_awlen_i, axi_awsize_i, axi_awburst_i,
           axi_awlock_i, axi_awcache_i, axi_awprot_i, axi_awqos_i, axi_awvalid_i,
           axi_wdata_i, axi_wstrb_i, axi_wlast_i, axi_wvalid_i, axi_bready_i,
           axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arsize_i, axi_arburst_i,
           axi_arlock_i, axi_arcache_i, axi_arprot_i, axi_arqos_i, axi_arvalid_i,
           axi_rready_i,
    output axi_awready_o, axi_wready_o, axi_bid_o, axi_bresp_o, axi_bvalid_o,
           axi_arready_o, axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o, axi_rvalid_o
  );

  modport master (
    output axi_awid_i, axi_awaddr_i, axi_awlen_i, axi_awsize_i, axi_awburst_i,
           axi_awlock_i, axi_awcache_i, axi_awprot_i, axi_awqos_i, axi_awvalid_i,
           axi_wdata_i, axi_wstrb_i, axi_wlast_i, axi_wvalid_i, axi_bready_i,
           axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arsize_i, axi_arburst_i,
           axi_arlock_i, axi_arcache_i, axi_arprot_i, axi_arqos_i, axi_arvalid_i,
           axi_rready_i,
    input  axi_awready_o, axi_wready_o, axi_bid_o, axi_bresp_o, axi_bvalid_o,
           axi_arready_o, axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o, axi_rvalid_o
  );
endinterface

// File: rtl/iob_axi_mem_responder.sv
// AXI4 responder backed by a simple dual-port RAM. Independent write and read
// engines; INCR/FIXED bursts at full bus width, anything else answers SLVERR.
module iob_axi_mem_responder #(
  parameter int AXI_ID_W   = 1,
  parameter int AXI_LEN_W  = 4,
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_DATA_W = 32,
  parameter int MEM_ADDR_W = 12
) (
  input logic                    clk_i,
  input logic                    arstn_i,
  iob_axi_mem_responder_if.slave axi
);
  localparam int OFF    = $clog2(AXI_DATA_W/8);
  localparam int STRB_W = AXI_DATA_W/8;
  localparam int DEPTH  = 2**MEM_ADDR_W;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] BURST_FIXED = 2'd0;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  // Only full-width INCR/FIXED bursts are serviced.
  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'(OFF)) || burst[1];
  endfunction

  logic [AXI_DATA_W-1:0] mem [DEPTH];

  // ---------------- write engine ----------------
  w_state_e              w_state_q, w_state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [AXI_ID_W-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [MEM_ADDR_W-1:0] waddr_q, waddr_d;
  logic [AXI_LEN_W-1:0]  wlen_q, wlen_d;
  logic [AXI_LEN_W-1:0]  wcnt_q, wcnt_d;
  logic                  werr_q, werr_d;
  logic                  wlerr_q, wlerr_d;
  logic                  wfixed_q, wfixed_d;
  logic                  ram_we;

  // Write next-state: accept AW, count W beats, then hold B until taken.
  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    wlerr_d   = wlerr_q;
    wfixed_d  = wfixed_q;
    ram_we    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (axi.axi_awvalid_i && awready_q) begin
          awready_d = 1'b0;
          wready_d  = 1'b1;
          bid_d     = axi.axi_awid_i;
          waddr_d   = axi.axi_awaddr_i[MEM_ADDR_W+OFF-1:OFF];
          wlen_d    = axi.axi_awlen_i;
          wcnt_d    = '0;
          werr_d    = burst_err(axi.axi_awsize_i, axi.axi_awburst_i);
          wlerr_d   = 1'b0;
          wfixed_d  = (axi.axi_awburst_i == BURST_FIXED);
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (axi.axi_wvalid_i && wready_q) begin
          ram_we = !werr_q;
          // beat count terminates the burst; wlast is only cross-checked
          if (axi.axi_wlast_i != (wcnt_q == wlen_q)) wlerr_d = 1'b1;
          if (!wfixed_q) waddr_d = waddr_q + MEM_ADDR_W'(1);
          wcnt_d = wcnt_q + AXI_LEN_W'(1);
          if (wcnt_q == wlen_q) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (werr_q || wlerr_d) ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (axi.axi_bready_i) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write engine state and registered outputs.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      wlerr_q   <= 1'b0;
      wfixed_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      wlerr_q   <= wlerr_d;
      wfixed_q  <= wfixed_d;
    end
  end

  // RAM write port with per-byte enables.
  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (axi.axi_wstrb_i[b]) mem[waddr_q][8*b +: 8] <= axi.axi_wdata_i[8*b +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [AXI_ID_W-1:0]   rid_q, rid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [MEM_ADDR_W-1:0] raddr_q, raddr_d;
  logic [AXI_LEN_W-1:0]  rlen_q, rlen_d;
  logic [AXI_LEN_W-1:0]  rcnt_q, rcnt_d;
  logic                  rerr_q, rerr_d;
  logic                  rfixed_q, rfixed_d;
  logic                  rd_en;
  logic [AXI_DATA_W-1:0] ram_rd_q;

  // Read next-state: raddr_q always points at the next word to fetch; the RAM
  // output register only advances on an accepted beat, so rdata holds in stalls.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    rerr_d    = rerr_q;
    rfixed_d  = rfixed_q;
    rd_en     = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (axi.axi_arvalid_i && arready_q) begin
          arready_d = 1'b0;
          rid_d     = axi.axi_arid_i;
          raddr_d   = axi.axi_araddr_i[MEM_ADDR_W+OFF-1:OFF];
          rlen_d    = axi.axi_arlen_i;
          rerr_d    = burst_err(axi.axi_arsize_i, axi.axi_arburst_i);
          rfixed_d  = (axi.axi_arburst_i == BURST_FIXED);
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        rd_en     = 1'b1;
        if (!rfixed_q) raddr_d = raddr_q + MEM_ADDR_W'(1);
        rvalid_d  = 1'b1;
        rresp_d   = rerr_q ? RESP_SLVERR : RESP_OKAY;
        rlast_d   = (rlen_q == '0);
        rcnt_d    = '0;
        r_state_d = R_DATA;
      end
      R_DATA: begin
        if (axi.axi_rready_i) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            rd_en   = 1'b1;
            if (!rfixed_q) raddr_d = raddr_q + MEM_ADDR_W'(1);
            rcnt_d  = rcnt_q + AXI_LEN_W'(1);
            rlast_d = ((rcnt_q + AXI_LEN_W'(1)) == rlen_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read engine state and registered outputs.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rerr_q    <= 1'b0;
      rfixed_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      rerr_q    <= rerr_d;
      rfixed_q  <= rfixed_d;
    end
  end

  // RAM read port; errored bursts load zero. Same-cycle write to the word is not seen.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) ram_rd_q <= '0;
    else if (rd_en) ram_rd_q <= rerr_q ? '0 : mem[raddr_q];
  end

  assign axi.axi_awready_o = awready_q;
  assign axi.axi_wready_o  = wready_q;
  assign axi.axi_bvalid_o  = bvalid_q;
  assign axi.axi_bid_o     = bid_q;
  assign axi.axi_bresp_o   = bresp_q;
  assign axi.axi_arready_o = arready_q;
  assign axi.axi_rvalid_o  = rvalid_q;
  assign axi.axi_rlast_o   = rlast_q;
  assign axi.axi_rid_o     = rid_q;
  assign axi.axi_rresp_o   = rresp_q;
  assign axi.axi_rdata_o   = ram_rd_q;

  // Sideband attributes and aliased address bits are accepted but have no effect.
  logic unused_inputs;
  assign unused_inputs = ^{axi.axi_awlock_i, axi.axi_awcache_i, axi.axi_awprot_i, axi.axi_awqos_i,
                           axi.axi_arlock_i, axi.axi_arcache_i, axi.axi_arprot_i, axi.axi_arqos_i,
                           axi.axi_awaddr_i, axi.axi_araddr_i};
endmodule

// File: tb/tb_iob_axi_mem_responder.sv
// Self-checking bench: directed scenarios plus randomized bursts against a
// byte-level memory model.
module tb_iob_axi_mem_responder;
  localparam int DEPTH = 4096;
  localparam logic [1:0] FIXED = 2'd0;
  localparam logic [1:0] INCR  = 2'd1;
  localparam logic [1:0] WRAP  = 2'd2;

  logic clk_i = 1'b0;
  logic arstn_i = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [3:0]  kn [DEPTH];
  logic [31:0] wbuf_d [16];
  logic [3:0]  wbuf_s [16];

  iob_axi_mem_responder_if #(.AXI_ID_W(1), .AXI_LEN_W(4), .AXI_ADDR_W(24), .AXI_DATA_W(32)) axi();

  iob_axi_mem_responder #(
    .AXI_ID_W(1), .AXI_LEN_W(4), .AXI_ADDR_W(24), .AXI_DATA_W(32), .MEM_ADDR_W(12)
  ) dut (
    .clk_i(clk_i),
    .arstn_i(arstn_i),
    .axi(axi)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int word_of(input logic [23:0] a);
    return int'(a >> 2) % DEPTH;
  endfunction

  function automatic int beat_word(input logic [23:0] a, input logic [1:0] burst, input int i);
    return (word_of(a) + ((burst == INCR) ? i : 0)) % DEPTH;
  endfunction

  task automatic axi_write(input logic [0:0] id, input logic [23:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int last_at, input int bdly, input bit wgap);
    int n;
    int w;
    bit err;
    logic [1:0] exp_resp;
    err = (size != 3'd2) || (burst >= WRAP);
    exp_resp = (err || last_at != len) ? 2'd2 : 2'd0;
    axi.axi_awid_i = id;
    axi.axi_awaddr_i = addr;
    axi.axi_awlen_i = 4'(len);
    axi.axi_awsize_i = size;
    axi.axi_awburst_i = burst;
    axi.axi_awvalid_i = 1'b1;
    n = 0;
    while (!axi.axi_awready_o && n < 100) begin step(); n++; end
    check("aw_ready", axi.axi_awready_o, 1'b1);
    step();
    axi.axi_awvalid_i = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (wgap && $urandom_range(0, 3) == 0) begin
        axi.axi_wvalid_i = 1'b0;
        step();
      end
      axi.axi_wvalid_i = 1'b1;
      axi.axi_wdata_i = wbuf_d[i];
      axi.axi_wstrb_i = wbuf_s[i];
      axi.axi_wlast_i = (i == last_at);
      n = 0;
      while (!axi.axi_wready_o && n < 100) begin step(); n++; end
      if (!axi.axi_wready_o) check("w_ready", axi.axi_wready_o, 1'b1);
      step();
    end
    axi.axi_wvalid_i = 1'b0;
    axi.axi_wlast_i = 1'b0;
    n = 0;
    while (!axi.axi_bvalid_o && n < 100) begin step(); n++; end
    check("b_valid", axi.axi_bvalid_o, 1'b1);
    for (int i = 0; i < bdly; i++) begin
      step();
      check("b_hold", axi.axi_bvalid_o, 1'b1);
    end
    check("b_id", axi.axi_bid_o, id);
    check("b_resp", axi.axi_bresp_o, exp_resp);
    axi.axi_bready_i = 1'b1;
    step();
    axi.axi_bready_i = 1'b0;
    check("b_clear", axi.axi_bvalid_o, 1'b0);
    check("aw_ready_after_b", axi.axi_awready_o, 1'b1);
    if (!err) begin
      for (int i = 0; i <= len; i++) begin
        w = beat_word(addr, burst, i);
        for (int b = 0; b < 4; b++) begin
          if (wbuf_s[i][b]) begin
            ref_mem[w][8*b +: 8] = wbuf_d[i][8*b +: 8];
            kn[w][b] = 1'b1;
          end
        end
      end
    end
  endtask

  // rmode: 0 rready always high, 1 toggles every cycle, 2 random
  task automatic axi_read(input logic [0:0] id, input logic [23:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int rmode, input bit chk_lat);
    int n;
    int lat;
    int beat;
    int cyc;
    int gaps;
    int w;
    bit err;
    logic [31:0] mask;
    logic [31:0] exp_d;
    err = (size != 3'd2) || (burst >= WRAP);
    axi.axi_arid_i = id;
    axi.axi_araddr_i = addr;
    axi.axi_arlen_i = 4'(len);
    axi.axi_arsize_i = size;
    axi.axi_arburst_i = burst;
    axi.axi_arvalid_i = 1'b1;
    n = 0;
    while (!axi.axi_arready_o && n < 100) begin step(); n++; end
    check("ar_ready", axi.axi_arready_o, 1'b1);
    step();
    axi.axi_arvalid_i = 1'b0;
    lat = 1;
    while (!axi.axi_rvalid_o && lat < 100) begin step(); lat++; end
    check("r_valid", axi.axi_rvalid_o, 1'b1);
    if (chk_lat) check("r_latency", lat, 2);
    beat = 0;
    cyc = 0;
    gaps = 0;
    while (beat <= len && cyc < 400) begin
      axi.axi_rready_i = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
      if (axi.axi_rvalid_o) begin
        w = beat_word(addr, burst, beat);
        if (err) begin
          mask = '1;
          exp_d = '0;
        end else begin
          for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{kn[w][b]}};
          exp_d = ref_mem[w] & mask;
        end
        if (mask != '0) check("r_data", axi.axi_rdata_o & mask, exp_d);
        check("r_last", axi.axi_rlast_o, beat == len);
        check("r_resp", axi.axi_rresp_o, err ? 2'd2 : 2'd0);
        check("r_id", axi.axi_rid_o, id);
        if (axi.axi_rready_i) beat++;
      end else begin
        gaps++;
      end
      step();
      cyc++;
    end
    axi.axi_rready_i = 1'b0;
    check("r_beats", beat, len + 1);
    check("r_done", axi.axi_rvalid_o, 1'b0);
    if (rmode == 0) check("r_no_gaps", gaps, 0);
  endtask

  initial begin
    int n;
    int len;
    logic [23:0] a;
    logic [1:0] bt;
    logic [2:0] sz;
    for (int i = 0; i < DEPTH; i++) kn[i] = 4'h0;
    axi.axi_awid_i = '0; axi.axi_awaddr_i = '0; axi.axi_awlen_i = '0; axi.axi_awsize_i = '0;
    axi.axi_awburst_i = '0; axi.axi_awlock_i = '0; axi.axi_awcache_i = '0; axi.axi_awprot_i = '0;
    axi.axi_awqos_i = '0; axi.axi_awvalid_i = 1'b0;
    axi.axi_wdata_i = '0; axi.axi_wstrb_i = '0; axi.axi_wlast_i = 1'b0; axi.axi_wvalid_i = 1'b0;
    axi.axi_bready_i = 1'b0;
    axi.axi_arid_i = '0; axi.axi_araddr_i = '0; axi.axi_arlen_i = '0; axi.axi_arsize_i = '0;
    axi.axi_arburst_i = '0; axi.axi_arlock_i = '0; axi.axi_arcache_i = '0; axi.axi_arprot_i = '0;
    axi.axi_arqos_i = '0; axi.axi_arvalid_i = 1'b0; axi.axi_rready_i = 1'b0;

    // reset state
    #1;
    check("rst_awready", axi.axi_awready_o, 1'b0);
    check("rst_arready", axi.axi_arready_o, 1'b0);
    check("rst_wready", axi.axi_wready_o, 1'b0);
    check("rst_bvalid", axi.axi_bvalid_o, 1'b0);
    check("rst_rvalid", axi.axi_rvalid_o, 1'b0);
    check("rst_rdata", axi.axi_rdata_o, 32'h0);
    repeat (3) step();
    arstn_i = 1'b1;
    step();
    check("rel_awready", axi.axi_awready_o, 1'b1);
    check("rel_arready", axi.axi_arready_o, 1'b1);

    // single beat write/read with latency
    wbuf_d[0] = 32'hDEADBEEF; wbuf_s[0] = 4'hF;
    axi_write(1'b1, 24'h10, 0, 3'd2, INCR, 0, 0, 1'b0);
    axi_read(1'b1, 24'h10, 0, 3'd2, INCR, 0, 1'b1);

    // INCR len 3, sustained reads
    for (int i = 0; i < 4; i++) begin wbuf_d[i] = 32'(i + 1); wbuf_s[i] = 4'hF; end
    axi_write(1'b0, 24'h100, 3, 3'd2, INCR, 3, 0, 1'b0);
    axi_read(1'b0, 24'h100, 3, 3'd2, INCR, 0, 1'b1);

    // byte strobes merge into an existing word
    wbuf_d[0] = 32'hFFFFFFFF; wbuf_s[0] = 4'hF;
    axi_write(1'b0, 24'h20, 0, 3'd2, INCR, 0, 1, 1'b0);
    wbuf_d[0] = 32'h00AB0000; wbuf_s[0] = 4'b0100;
    axi_write(1'b0, 24'h20, 0, 3'd2, INCR, 0, 0, 1'b0);
    check("strb_model", ref_mem[8], 32'hFFABFFFF);
    axi_read(1'b0, 24'h20, 0, 3'd2, INCR, 0, 1'b1);

    // len 7 with rready toggling every cycle
    for (int i = 0; i < 8; i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'hF; end
    axi_write(1'b1, 24'h300, 7, 3'd2, INCR, 7, 2, 1'b1);
    axi_read(1'b1, 24'h300, 7, 3'd2, INCR, 1, 1'b1);

    // size error: SLVERR, RAM unchanged
    wbuf_d[0] = 32'h12345678; wbuf_s[0] = 4'hF;
    axi_write(1'b1, 24'h10, 0, 3'd1, INCR, 0, 0, 1'b0);
    axi_read(1'b0, 24'h10, 0, 3'd2, INCR, 0, 1'b0);
    // WRAP read: SLVERR beats with zero data
    axi_read(1'b1, 24'h100, 3, 3'd2, WRAP, 0, 1'b1);
    // early wlast on beat 2 of 4, and missing wlast
    for (int i = 0; i < 4; i++) begin wbuf_d[i] = 32'hA0 + 32'(i); wbuf_s[i] = 4'hF; end
    axi_write(1'b0, 24'h400, 3, 3'd2, INCR, 1, 0, 1'b0);
    axi_read(1'b0, 24'h400, 3, 3'd2, INCR, 0, 1'b0);
    axi_write(1'b0, 24'h440, 3, 3'd2, INCR, -1, 0, 1'b0);
    // INCR across the top of the RAM wraps to word 0
    wbuf_d[0] = 32'hCAFE0001; wbuf_d[1] = 32'hCAFE0002; wbuf_s[0] = 4'hF; wbuf_s[1] = 4'hF;
    axi_write(1'b1, 24'h3FFC, 1, 3'd2, INCR, 1, 0, 1'b0);
    axi_read(1'b1, 24'h3FFC, 1, 3'd2, INCR, 0, 1'b0);
    axi_read(1'b0, 24'h0, 0, 3'd2, INCR, 0, 1'b0);
    check("wrap_word0_model", ref_mem[0], 32'hCAFE0002);
    // high address bits alias; FIXED burst holds the address
    axi_read(1'b0, 24'h010010, 0, 3'd2, INCR, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin wbuf_d[i] = 32'hF00 + 32'(i); wbuf_s[i] = 4'hF; end
    axi_write(1'b0, 24'h600, 2, 3'd2, FIXED, 2, 0, 1'b0);
    axi_read(1'b0, 24'h600, 3, 3'd2, FIXED, 2, 1'b0);

    // reset during read beat 2
    for (int i = 0; i < 8; i++) begin wbuf_d[i] = 32'h7000 + 32'(i); wbuf_s[i] = 4'hF; end
    axi_write(1'b0, 24'h200, 7, 3'd2, INCR, 7, 0, 1'b0);
    axi.axi_arid_i = 1'b0; axi.axi_araddr_i = 24'h200; axi.axi_arlen_i = 4'd7;
    axi.axi_arsize_i = 3'd2; axi.axi_arburst_i = INCR; axi.axi_arvalid_i = 1'b1;
    n = 0;
    while (!axi.axi_arready_o && n < 100) begin step(); n++; end
    step();
    axi.axi_arvalid_i = 1'b0;
    n = 0;
    while (!axi.axi_rvalid_o && n < 100) begin step(); n++; end
    axi.axi_rready_i = 1'b1;
    step();
    axi.axi_rready_i = 1'b0;
    check("mid_beat2_valid", axi.axi_rvalid_o, 1'b1);
    check("mid_beat2_data", axi.axi_rdata_o, 32'h7001);
    arstn_i = 1'b0;
    #1;
    check("mid_rst_rvalid", axi.axi_rvalid_o, 1'b0);
    check("mid_rst_rlast", axi.axi_rlast_o, 1'b0);
    check("mid_rst_rdata", axi.axi_rdata_o, 32'h0);
    check("mid_rst_arready", axi.axi_arready_o, 1'b0);
    step();
    arstn_i = 1'b1;
    step();
    check("mid_rel_arready", axi.axi_arready_o, 1'b1);
    check("mid_rel_awready", axi.axi_awready_o, 1'b1);
    wbuf_d[0] = 32'h5A5A5A5A; wbuf_s[0] = 4'hF;
    axi_write(1'b1, 24'h500, 0, 3'd2, INCR, 0, 0, 1'b0);
    axi_read(1'b1, 24'h500, 0, 3'd2, INCR, 0, 1'b1);
    axi_read(1'b0, 24'h200, 7, 3'd2, INCR, 2, 1'b0);

    // randomized bursts, some with a concurrent write to a disjoint region
    for (int t = 0; t < 30; t++) begin
      len = $urandom_range(0, 7);
      a = 24'(($urandom_range(0, 2000) + 1024) * 4);
      bt = 2'($urandom_range(0, 1));
      for (int i = 0; i <= len; i++) begin
        wbuf_d[i] = $urandom;
        wbuf_s[i] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      end
      axi_write(1'($urandom), a, len, 3'd2, bt, len, $urandom_range(0, 2), 1'b1);
      sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'd2;
      bt = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 1));
      if (t % 4 == 0) begin
        for (int i = 0; i <= 7; i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'hF; end
        fork
          axi_read(1'($urandom), a, len, sz, bt, 2, 1'b1);
          axi_write(1'b0, 24'($urandom_range(100, 900) * 4), 7, 3'd2, INCR, 7, 0, 1'b1);
        join
      end else begin
        axi_read(1'($urandom), a, len, sz, bt, 2, 1'b1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
